wb_stage: RTL and testbench



---
 rtl/wb_stage_pkg.sv | 20 ++
 rtl/wb_load_fmt.sv | 29 ++
 rtl/wb_stage.sv | 102 ++++++++++
 tb/tb_wb_stage.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared constants for the MIPS write-back stage: control bit indices,
// load-size encodings and FSM states.
package wb_stage_pkg;
  localparam int NB_CTR_WB = 4;

  localparam int WB_WE    = 0;
  localparam int WB_M2R   = 1;
  localparam int WB_VALID = 2;
  localparam int WB_HALT  = 3;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b11;
  localparam int LD_UNSIGNED = 2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;
endpackage

// File: rtl/wb_load_fmt.sv
// Little-endian byte/half/word extraction with sign or zero extension.
module wb_load_fmt
  import wb_stage_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int NB_LD   = 3
) (
  input  logic [NB_BITS-1:0] i_mem_data,
  input  logic [1:0]         i_addr_lsb,
  input  logic [NB_LD-1:0]   i_ld_ctl,
  output logic [NB_BITS-1:0] o_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        uns;

  always_comb begin
    byte_sel = i_mem_data[8*i_addr_lsb +: 8];
    half_sel = i_mem_data[16*i_addr_lsb[1] +: 16];
    uns      = i_ld_ctl[LD_UNSIGNED];
    o_data   = i_mem_data;
    // Size 2'b10 is not a real encoding and falls through as a word load.
    case (i_ld_ctl[1:0])
      LD_BYTE: o_data = {{(NB_BITS-8){byte_sel[7] & ~uns}}, byte_sel};
      LD_HALF: o_data = {{(NB_BITS-16){half_sel[15] & ~uns}}, half_sel};
      default: o_data = i_mem_data;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: result mux, register-file write port, forwarding
// copy of the last write, HALT FSM and debug counters.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int NB_REG  = 5,
  parameter int NB_WB   = NB_CTR_WB,
  parameter int NB_LD   = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_mem_data,
  input  logic [NB_BITS-1:0] i_alu_data,
  input  logic [1:0]         i_addr_lsb,
  input  logic [NB_REG-1:0]  i_reg_dst,
  input  logic [NB_WB-1:0]   i_wb_ctl,
  input  logic [NB_LD-1:0]   i_ld_ctl,
  input  logic               i_wb_en,
  output logic [NB_BITS-1:0] o_wb_data,
  output logic [NB_REG-1:0]  o_reg_dst,
  output logic               o_wb_rf_webn,
  output logic [NB_BITS-1:0] o_fwd_data,
  output logic [NB_REG-1:0]  o_fwd_reg,
  output logic               o_fwd_valid,
  output logic               o_halt,
  output logic [31:0]        o_cycles,
  output logic [31:0]        o_retired
);
  wb_state_e          state_q, state_d;
  logic [NB_BITS-1:0] fwd_data_q, fwd_data_d;
  logic [NB_REG-1:0]  fwd_reg_q, fwd_reg_d;
  logic               fwd_valid_q, fwd_valid_d;
  logic [31:0]        cycles_q, cycles_d;
  logic [31:0]        retired_q, retired_d;

  logic [NB_BITS-1:0] ld_data;
  logic               advance;
  logic               rf_we;

  wb_load_fmt #(.NB_BITS(NB_BITS), .NB_LD(NB_LD)) u_load_fmt (
    .i_mem_data (i_mem_data),
    .i_addr_lsb (i_addr_lsb),
    .i_ld_ctl   (i_ld_ctl),
    .o_data     (ld_data)
  );

  assign advance = (state_q == ST_RUN) && i_wb_en;
  // Halt retires but never writes; $0 is hardwired zero.
  assign rf_we   = advance && !i_rst && i_wb_ctl[WB_VALID] && i_wb_ctl[WB_WE] &&
                   !i_wb_ctl[WB_HALT] && (i_reg_dst != '0);

  assign o_wb_data    = i_wb_ctl[WB_M2R] ? ld_data : i_alu_data;
  assign o_reg_dst    = i_reg_dst;
  assign o_wb_rf_webn = rf_we;

  always_comb begin
    state_d     = state_q;
    fwd_data_d  = fwd_data_q;
    fwd_reg_d   = fwd_reg_q;
    fwd_valid_d = fwd_valid_q;
    cycles_d    = cycles_q;
    retired_d   = retired_q;
    if (advance) begin
      cycles_d = cycles_q + 32'd1;
      if (i_wb_ctl[WB_VALID]) begin
        retired_d = retired_q + 32'd1;
        if (i_wb_ctl[WB_HALT]) state_d = ST_HALTED;
      end
      if (rf_we) begin
        fwd_data_d  = o_wb_data;
        fwd_reg_d   = i_reg_dst;
        fwd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      fwd_data_q  <= '0;
      fwd_reg_q   <= '0;
      fwd_valid_q <= 1'b0;
      cycles_q    <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      fwd_data_q  <= fwd_data_d;
      fwd_reg_q   <= fwd_reg_d;
      fwd_valid_q <= fwd_valid_d;
      cycles_q    <= cycles_d;
      retired_q   <= retired_d;
    end
  end

  assign o_fwd_data  = fwd_data_q;
  assign o_fwd_reg   = fwd_reg_q;
  assign o_fwd_valid = fwd_valid_q;
  assign o_halt      = (state_q == ST_HALTED);
  assign o_cycles    = cycles_q;
  assign o_retired   = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected write-port and registered outputs
// are queued when a cycle is driven and popped when the DUT is sampled.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_data, alu_data;
  logic [1:0]  addr_lsb;
  logic [4:0]  reg_dst;
  logic [3:0]  wb_ctl;
  logic [2:0]  ld_ctl;
  logic        wb_en;
  logic [31:0] wb_data, fwd_data, cycles, retired;
  logic [4:0]  o_dst, fwd_reg;
  logic        webn, fwd_valid, halt;

  wb_stage dut (
    .i_clk(clk), .i_rst(rst), .i_mem_data(mem_data), .i_alu_data(alu_data),
    .i_addr_lsb(addr_lsb), .i_reg_dst(reg_dst), .i_wb_ctl(wb_ctl),
    .i_ld_ctl(ld_ctl), .i_wb_en(wb_en), .o_wb_data(wb_data),
    .o_reg_dst(o_dst), .o_wb_rf_webn(webn), .o_fwd_data(fwd_data),
    .o_fwd_reg(fwd_reg), .o_fwd_valid(fwd_valid), .o_halt(halt),
    .o_cycles(cycles), .o_retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [4:0] dst; logic we; } comb_t;
  typedef struct {
    logic [31:0] fdata; logic [4:0] freg; logic fvld; logic hlt;
    logic [31:0] cyc; logic [31:0] ret;
  } regs_t;
  comb_t comb_q[$];
  regs_t regs_q[$];

  // Reference state
  logic        m_halted = 1'b0, m_fvld = 1'b0;
  logic [31:0] m_fdata = '0, m_cyc = '0, m_ret = '0;
  logic [4:0]  m_freg = '0;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive one cycle. ld_exp is the expected formatted load when m2r=1.
  task automatic cyc(input logic r, input logic en, input logic [31:0] mem,
                     input logic [31:0] alu, input logic [1:0] lsb,
                     input logic [4:0] dst, input logic [3:0] wb,
                     input logic [2:0] ld, input logic [31:0] ld_exp);
    comb_t c; regs_t g;
    @(negedge clk);
    rst = r; wb_en = en; mem_data = mem; alu_data = alu; addr_lsb = lsb;
    reg_dst = dst; wb_ctl = wb; ld_ctl = ld;
    c.data = wb[1] ? ld_exp : alu;
    c.dst  = dst;
    c.we   = !r && en && !m_halted && wb[2] && wb[0] && !wb[3] && (dst != 5'd0);
    comb_q.push_back(c);
    #1;
    c = comb_q.pop_front();
    chk("wb_data", wb_data, c.data);
    chk("reg_dst", {27'd0, o_dst}, {27'd0, c.dst});
    chk("webn", {31'd0, webn}, {31'd0, c.we});
    @(posedge clk);
    if (r) begin
      m_halted = 0; m_fvld = 0; m_fdata = 0; m_freg = 0; m_cyc = 0; m_ret = 0;
    end else if (en && !m_halted) begin
      m_cyc++;
      if (wb[2]) m_ret++;
      if (c.we) begin m_fdata = c.data; m_freg = dst; m_fvld = 1; end
      if (wb[2] && wb[3]) m_halted = 1;
    end
    g = '{m_fdata, m_freg, m_fvld, m_halted, m_cyc, m_ret};
    regs_q.push_back(g);
    #1;
    g = regs_q.pop_front();
    chk("fwd_data", fwd_data, g.fdata);
    chk("fwd_reg", {27'd0, fwd_reg}, {27'd0, g.freg});
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, g.fvld});
    chk("halt", {31'd0, halt}, {31'd0, g.hlt});
    chk("cycles", cycles, g.cyc);
    chk("retired", retired, g.ret);
  endtask

  typedef struct { logic [31:0] mem; logic [1:0] lsb; logic [2:0] ld; logic [31:0] exp; } ld_t;
  ld_t lds[] = '{
    '{32'h80FF7F01, 2'd0, 3'b000, 32'h00000001},
    '{32'h80FF7F01, 2'd1, 3'b000, 32'h0000007F},
    '{32'h80FF7F01, 2'd2, 3'b000, 32'hFFFFFFFF},
    '{32'h80FF7F01, 2'd3, 3'b000, 32'hFFFFFF80},
    '{32'h80FF7F01, 2'd3, 3'b100, 32'h00000080},
    '{32'h80FF7F01, 2'd2, 3'b100, 32'h000000FF},
    '{32'h80FF7F01, 2'd1, 3'b100, 32'h0000007F},
    '{32'h8001FFFE, 2'd2, 3'b001, 32'hFFFF8001},
    '{32'h8001FFFE, 2'd0, 3'b101, 32'h0000FFFE},
    '{32'h8001FFFE, 2'd3, 3'b001, 32'hFFFF8001},
    '{32'h8001FFFE, 2'd0, 3'b001, 32'hFFFFFFFE},
    '{32'h8001FFFE, 2'd2, 3'b101, 32'h00008001},
    '{32'h8001FFFE, 2'd1, 3'b011, 32'h8001FFFE},
    '{32'h8001FFFE, 2'd2, 3'b010, 32'h8001FFFE}
  };

  localparam logic [3:0] ALU_W = 4'b0101, LD_W = 4'b0111, BUB = 4'b0000,
                         HLT_W = 4'b1101, VAL_NW = 4'b0100;

  initial begin
    rst = 1; wb_en = 1; mem_data = 0; alu_data = 0; addr_lsb = 0;
    reg_dst = 0; wb_ctl = 0; ld_ctl = 0;
    // Reset with a write presented: dropped
    cyc(1, 1, 0, 32'hDEAD, 0, 5'd9, ALU_W, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, BUB, 0, 0);

    foreach (lds[i]) cyc(0, 1, lds[i].mem, 32'h0BAD, lds[i].lsb, 5'd3, LD_W, lds[i].ld, lds[i].exp);

    cyc(0, 1, 0, 32'h1234, 0, 5'd5, ALU_W, 0, 0);
    chk("fwd_r5", fwd_data, 32'h1234);
    cyc(0, 1, 0, 32'h5555, 0, 5'd0, ALU_W, 0, 0);
    cyc(0, 1, 0, 32'h7777, 0, 5'd6, VAL_NW, 0, 0);
    chk("fwd_keep", {27'd0, fwd_reg}, 32'd5);

    // Frozen stage, even with halt presented
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'hAAAA, 0, 5'd7, (i == 2) ? HLT_W : ALU_W, 0, 0);
    cyc(0, 1, 0, 32'hAAAA, 0, 5'd7, ALU_W, 0, 0);

    // Halt sequence from a clean reset
    cyc(1, 1, 0, 0, 0, 0, BUB, 0, 0);
    cyc(0, 1, 0, 32'h11, 0, 5'd1, ALU_W, 0, 0);
    cyc(0, 1, 0, 32'h22, 0, 5'd2, BUB, 0, 0);
    cyc(0, 1, 0, 32'h33, 0, 5'd3, ALU_W, 0, 0);
    cyc(0, 1, 0, 32'h44, 0, 5'd4, HLT_W, 0, 0);
    chk("ret_at_halt", retired, 32'd3);
    chk("cyc_at_halt", cycles, 32'd4);
    chk("fwd_no_halt_wr", fwd_data, 32'h33);
    for (int i = 0; i < 11; i++) cyc(0, 1, 0, 32'h55 + i, 0, 5'd8, ALU_W, 0, 0);

    // Reset while halted, with a write presented
    cyc(1, 1, 0, 32'h66, 0, 5'd9, ALU_W, 0, 0);
    cyc(0, 1, 0, 32'h77, 0, 5'd10, ALU_W, 0, 0);
    chk("post_rst_fwd", fwd_data, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end
endmodule
